hv_timing_gen: RTL and testbench
================================

HV_TIMING_GEN -- requirements
Module: hv_timing_gen

Interface
REQ-001 SHALL have parameter DW, default 12: RGB bus width.
REQ-002 SHALL have parameter CW, default 9: HPOS/VPOS counter width.
REQ-003 SHALL have parameters H_ACT 288, H_SS 288, H_SE 312, H_TOTAL 384: active width, hsync start, hsync end (exclusive), line length, all in pixels.
REQ-004 SHALL have parameters V_ACT 224, V_SS 227, V_SE 234, V_TOTAL 263: the same four values for the vertical axis, in lines.
REQ-005 SHALL have parameters HS_POL 0 and VS_POL 0: sync active level, where 0 means active-low.
REQ-006 SHALL have parameter BLANK_LEFT, default 2: count of leading active pixels forced to black.
REQ-007 SHALL have one clock and an asynchronous, active-low reset.
REQ-008 Port list, clock and reset first:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous reset, active low.
- CE  in  1  pixel enable; the block advances only on CLK edges with CE=1.
- HOFS  in  4  signed hsync shift in pixels, range -8..+7.
- VOFS  in  4  signed vsync shift in lines, range -8..+7.
- iRGB  in  DW  pixel data.
- HPOS  out  CW  horizontal counter.
- VPOS  out  CW  vertical counter.
- HBLK  out  1  horizontal blank.
- VBLK  out  1  vertical blank.
- HSYN  out  1  horizontal sync.
- VSYN  out  1  vertical sync.
- LSTART  out  1  line-start strobe.
- FSTART  out  1  frame-start strobe.
- oRGB  out  DW  blanked pixel data.

Function
REQ-009 On each CE: HPOS increments; HPOS=H_TOTAL-1 wraps to 0 and advances VPOS; VPOS=V_TOTAL-1 on that same wrap returns to 0.
REQ-010 CE=0 SHALL hold every register, including strobes, which drop to 0 on the next CLK.
REQ-011 HBLK, VBLK, HSYN and VSYN SHALL be registered and aligned to the current HPOS/VPOS:
- HBLK = (HPOS >= H_ACT).
- VBLK = (VPOS >= V_ACT).
REQ-012 HSYN SHALL be at active level exactly while H_SS+ho <= HPOS < H_SE+ho; otherwise inactive.
REQ-013 VSYN SHALL be at active level exactly while V_SS+vo <= VPOS < V_SE+vo; otherwise inactive.
REQ-014 ho/vo are latched copies of HOFS/VOFS, sign-extended, taken only on the CE where the counters wrap to (0,0); changes mid-frame SHALL NOT take effect until the next frame.
REQ-015 Window arithmetic SHALL be done at CW+1 bits signed; a window bound below 0 or at or above TOTAL SHALL be clamped to 0 or TOTAL-1 respectively, with no wrap across the line or frame.
REQ-016 LSTART SHALL be a one-CLK pulse, aligned with HPOS=0, on the CE that produced HPOS=0.
REQ-017 FSTART SHALL be a one-CLK pulse when HPOS=0 and VPOS=0 are produced by a CE; it coincides with LSTART.
REQ-018 oRGB SHALL be registered on CE as 0 if HBLK, VBLK or HPOS<BLANK_LEFT (pre-update values), else iRGB; latency 1 CE versus HPOS.
REQ-019 Parameters SHALL satisfy H_ACT<=H_SS<H_SE<=H_TOTAL and V_ACT<=V_SS<V_SE<=V_TOTAL; a violation SHALL stop elaboration with an error.
REQ-020 Both totals SHALL be < 2^CW; otherwise elaboration SHALL fail.

Reset
REQ-021 RESET_N=0 SHALL asynchronously force these values:
- HPOS=0, VPOS=0.
- HBLK=1, VBLK=1.
- HSYN and VSYN at inactive level.
- LSTART=0, FSTART=0.
- oRGB=0.
- ho=0, vo=0.
REQ-022 After release, the first CE SHALL yield HPOS=1, VPOS=0, with HBLK and VBLK at their decoded values.
REQ-023 Assertion of reset mid-frame SHALL discard the latched offsets and the frame position; no strobe SHALL be emitted during reset.

Verification
REQ-024 Defaults, CE=1 continuously, iRGB=12'hFFF, HOFS=VOFS=0:
- Line period is 384 CE; frame period is 100992 CE.
- HSYN is low for HPOS 288..311; VSYN is low for VPOS 227..233.
- oRGB=0 for HPOS<=1 and for HPOS>=288.
REQ-025 CE asserted every 4th CLK: the frame period is 403968 CLK, and each strobe is exactly 1 CLK wide.
REQ-026 HOFS=+5 written mid-frame: the current frame keeps HSYN at 288..311; the next frame moves it to 293..316.
REQ-027 HOFS=-8 with H_SS=H_ACT=288: HSYN spans HPOS 280..303.
REQ-028 Reset asserted at HPOS=100, VPOS=50 with vo=3 latched: all outputs are at reset values immediately, and after release vo=0 until the next FSTART.
REQ-029 Parameters H_TOTAL=400, V_TOTAL=262, HS_POL=1: HSYN is high over the window, and FSTART fires every 104800 CE.

Source files
------------

// File: rtl/hv_timing_gen.sv
// Horizontal/vertical video timing generator: position counters, blanking, sync
// with per-frame offsets, line/frame strobes and blanked pixel output.
module hv_timing_gen #(
    parameter int DW         = 12,
    parameter int CW         = 9,
    parameter int H_ACT      = 288,
    parameter int H_SS       = 288,
    parameter int H_SE       = 312,
    parameter int H_TOTAL    = 384,
    parameter int V_ACT      = 224,
    parameter int V_SS       = 227,
    parameter int V_SE       = 234,
    parameter int V_TOTAL    = 263,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int BLANK_LEFT = 2
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          CE,
    input  logic [3:0]    HOFS,
    input  logic [3:0]    VOFS,
    input  logic [DW-1:0] iRGB,
    output logic [CW-1:0] HPOS,
    output logic [CW-1:0] VPOS,
    output logic          HBLK,
    output logic          VBLK,
    output logic          HSYN,
    output logic          VSYN,
    output logic          LSTART,
    output logic          FSTART,
    output logic [DW-1:0] oRGB
);

    if (!(H_ACT <= H_SS && H_SS < H_SE && H_SE <= H_TOTAL)) begin : g_bad_h
        $error("hv_timing_gen: horizontal timing parameters out of order");
    end
    if (!(V_ACT <= V_SS && V_SS < V_SE && V_SE <= V_TOTAL)) begin : g_bad_v
        $error("hv_timing_gen: vertical timing parameters out of order");
    end
    if (H_TOTAL >= (1 << CW) || V_TOTAL >= (1 << CW)) begin : g_bad_cw
        $error("hv_timing_gen: totals do not fit in CW bits");
    end

    localparam logic [CW-1:0]        H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0]        V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0]        H_ACT_U  = CW'(H_ACT);
    localparam logic [CW-1:0]        V_ACT_U  = CW'(V_ACT);
    localparam logic [CW-1:0]        BL_BOUND = CW'(BLANK_LEFT);
    localparam logic signed [CW:0]   H_LAST_S = (CW+1)'(H_TOTAL - 1);
    localparam logic signed [CW:0]   V_LAST_S = (CW+1)'(V_TOTAL - 1);
    localparam logic signed [CW:0]   H_SS_S   = (CW+1)'(H_SS);
    localparam logic signed [CW:0]   H_SE_S   = (CW+1)'(H_SE);
    localparam logic signed [CW:0]   V_SS_S   = (CW+1)'(V_SS);
    localparam logic signed [CW:0]   V_SE_S   = (CW+1)'(V_SE);
    localparam logic                 HS_ON    = (HS_POL != 0);
    localparam logic                 VS_ON    = (VS_POL != 0);

    // Window bounds are clamped into the line/frame rather than wrapping around.
    function automatic logic [CW-1:0] clamp_bound(input logic signed [CW:0] v,
                                                  input logic signed [CW:0] last);
        logic [CW-1:0] r;
        if (v[CW])
            r = '0;
        else if (v > last)
            r = last[CW-1:0];
        else
            r = v[CW-1:0];
        return r;
    endfunction

    logic [CW-1:0]        hpos_reg, hpos_next, vpos_reg, vpos_next;
    logic signed [CW:0]   ho_reg, ho_next, vo_reg, vo_next;
    logic [CW-1:0]        hs_lo, hs_hi, vs_lo, vs_hi;
    logic                 hblk_reg, hblk_next, vblk_reg, vblk_next;
    logic                 hsyn_reg, hsyn_next, vsyn_reg, vsyn_next;
    logic                 lstart_reg, fstart_reg;
    logic                 line_wrap, frame_wrap, pix_blank;
    logic [DW-1:0]        rgb_reg, rgb_next;

    always_comb begin
        line_wrap  = (hpos_reg == H_LAST);
        frame_wrap = line_wrap && (vpos_reg == V_LAST);
        hpos_next  = line_wrap ? '0 : hpos_reg + CW'(1);
        vpos_next  = vpos_reg;
        if (line_wrap)
            vpos_next = frame_wrap ? '0 : vpos_reg + CW'(1);
        // New offsets apply from the first position of the new frame onwards.
        ho_next = frame_wrap ? {{(CW-3){HOFS[3]}}, HOFS} : ho_reg;
        vo_next = frame_wrap ? {{(CW-3){VOFS[3]}}, VOFS} : vo_reg;
        hs_lo = clamp_bound(H_SS_S + ho_next, H_LAST_S);
        hs_hi = clamp_bound(H_SE_S + ho_next, H_LAST_S);
        vs_lo = clamp_bound(V_SS_S + vo_next, V_LAST_S);
        vs_hi = clamp_bound(V_SE_S + vo_next, V_LAST_S);
        hblk_next = (hpos_next >= H_ACT_U);
        vblk_next = (vpos_next >= V_ACT_U);
        hsyn_next = (hpos_next >= hs_lo && hpos_next < hs_hi) ? HS_ON : ~HS_ON;
        vsyn_next = (vpos_next >= vs_lo && vpos_next < vs_hi) ? VS_ON : ~VS_ON;
        pix_blank = hblk_reg || vblk_reg || (hpos_reg < BL_BOUND);
    end

    for (genvar gi = 0; gi < DW; gi++) begin : g_rgb
        assign rgb_next[gi] = iRGB[gi] & ~pix_blank;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hpos_reg   <= '0;
            vpos_reg   <= '0;
            ho_reg     <= '0;
            vo_reg     <= '0;
            hblk_reg   <= 1'b1;
            vblk_reg   <= 1'b1;
            hsyn_reg   <= ~HS_ON;
            vsyn_reg   <= ~VS_ON;
            lstart_reg <= 1'b0;
            fstart_reg <= 1'b0;
            rgb_reg    <= '0;
        end else begin
            lstart_reg <= 1'b0;
            fstart_reg <= 1'b0;
            if (CE) begin
                hpos_reg   <= hpos_next;
                vpos_reg   <= vpos_next;
                ho_reg     <= ho_next;
                vo_reg     <= vo_next;
                hblk_reg   <= hblk_next;
                vblk_reg   <= vblk_next;
                hsyn_reg   <= hsyn_next;
                vsyn_reg   <= vsyn_next;
                lstart_reg <= line_wrap;
                fstart_reg <= frame_wrap;
                rgb_reg    <= rgb_next;
            end
        end
    end

    assign HPOS   = hpos_reg;
    assign VPOS   = vpos_reg;
    assign HBLK   = hblk_reg;
    assign VBLK   = vblk_reg;
    assign HSYN   = hsyn_reg;
    assign VSYN   = vsyn_reg;
    assign LSTART = lstart_reg;
    assign FSTART = fstart_reg;
    assign oRGB   = rgb_reg;

endmodule

// File: tb/tb_hv_timing_gen.sv
// Self-checking bench for hv_timing_gen on a small raster (32x16) so whole
// frames, offset clamping and reset corner cases fit in a short run.
module tb_hv_timing_gen;

    localparam int DW = 12, CW = 7;
    localparam int HA = 20, HSS = 22, HSE = 26, HT = 32;
    localparam int VA = 10, VSS = 11, VSE = 13, VT = 16;
    localparam int HP = 0, VP = 1, BL = 2;
    localparam logic HS_ACT = (HP != 0);
    localparam logic VS_ACT = (VP != 0);

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          CE = 1'b0;
    logic [3:0]    HOFS = '0;
    logic [3:0]    VOFS = '0;
    logic [DW-1:0] iRGB = '0;
    logic [CW-1:0] HPOS, VPOS;
    logic          HBLK, VBLK, HSYN, VSYN, LSTART, FSTART;
    logic [DW-1:0] oRGB;

    hv_timing_gen #(
        .DW(DW), .CW(CW),
        .H_ACT(HA), .H_SS(HSS), .H_SE(HSE), .H_TOTAL(HT),
        .V_ACT(VA), .V_SS(VSS), .V_SE(VSE), .V_TOTAL(VT),
        .HS_POL(HP), .VS_POL(VP), .BLANK_LEFT(BL)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CE(CE), .HOFS(HOFS), .VOFS(VOFS),
        .iRGB(iRGB), .HPOS(HPOS), .VPOS(VPOS), .HBLK(HBLK), .VBLK(VBLK),
        .HSYN(HSYN), .VSYN(VSYN), .LSTART(LSTART), .FSTART(FSTART), .oRGB(oRGB)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: linear position within the frame plus per-frame offsets.
    int            m_pos, m_ho, m_vo;
    logic          m_hblk, m_vblk, m_hs, m_vs, m_ls, m_fs;
    logic [DW-1:0] m_rgb;

    function automatic int clampi(input int x, input int total);
        if (x < 0) return 0;
        if (x > total - 1) return total - 1;
        return x;
    endfunction

    function automatic int s4(input logic [3:0] x);
        return x[3] ? int'(x) - 16 : int'(x);
    endfunction

    task automatic model_reset();
        m_pos = 0; m_ho = 0; m_vo = 0;
        m_hblk = 1'b1; m_vblk = 1'b1; m_hs = 1'b0; m_vs = 1'b0;
        m_ls = 1'b0; m_fs = 1'b0; m_rgb = '0;
    endtask

    task automatic model_ce(input logic [DW-1:0] rgb, input logic [3:0] hofs,
                            input logic [3:0] vofs);
        int h, v;
        m_rgb = (m_hblk || m_vblk || (m_pos % HT) < BL) ? '0 : rgb;
        m_pos = (m_pos + 1) % (HT * VT);
        h = m_pos % HT;
        v = m_pos / HT;
        if (m_pos == 0) begin
            m_ho = s4(hofs);
            m_vo = s4(vofs);
        end
        m_hblk = (h >= HA);
        m_vblk = (v >= VA);
        m_hs = (h >= clampi(HSS + m_ho, HT)) && (h < clampi(HSE + m_ho, HT));
        m_vs = (v >= clampi(VSS + m_vo, VT)) && (v < clampi(VSE + m_vo, VT));
        m_ls = (h == 0);
        m_fs = (m_pos == 0);
    endtask

    function automatic logic [31:0] exp_vec();
        logic hl, vl;
        hl = m_hs ? HS_ACT : ~HS_ACT;
        vl = m_vs ? VS_ACT : ~VS_ACT;
        return {7'(m_pos % HT), 7'(m_pos / HT), m_hblk, m_vblk, hl, vl, m_ls, m_fs, m_rgb};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {HPOS, VPOS, HBLK, VBLK, HSYN, VSYN, LSTART, FSTART, oRGB};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic ce, input logic [DW-1:0] rgb,
                        input logic [3:0] hofs, input logic [3:0] vofs);
        CE = ce; iRGB = rgb; HOFS = hofs; VOFS = vofs;
        @(posedge CLK);
        #1;
        if (ce) model_ce(rgb, hofs, vofs);
        else begin
            m_ls = 1'b0;
            m_fs = 1'b0;
        end
        check("cycle", dut_vec(), exp_vec());
    endtask

    task automatic sync_frame(input logic [3:0] hofs, input logic [3:0] vofs);
        for (int i = 0; i < HT * VT + 1; i++) begin
            step(1'b1, DW'($urandom), hofs, vofs);
            if (FSTART) break;
        end
        check("sync_fstart", 32'(FSTART), 32'd1);
    endtask

    task automatic scan_line(input logic [3:0] hofs, output int mn, output int mx);
        mn = 999; mx = -1;
        for (int i = 0; i < HT; i++) begin
            step(1'b1, DW'($urandom), hofs, 4'd0);
            if (HSYN == HS_ACT) begin
                if (int'(HPOS) < mn) mn = int'(HPOS);
                if (int'(HPOS) > mx) mx = int'(HPOS);
            end
        end
        $display("line scan: hofs=%0d hsync active %0d..%0d", s4(hofs), mn, mx);
    endtask

    typedef struct {
        logic          ce;
        logic [DW-1:0] rgb;
        int            hpos;
        int            vpos;
        logic          hblk;
        logic [DW-1:0] orgb;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int mn, mx, period, ls_cnt;

        tbl[0] = '{1'b1, 12'hABC, 1, 0, 1'b0, 12'h000};
        tbl[1] = '{1'b0, 12'h111, 1, 0, 1'b0, 12'h000};
        tbl[2] = '{1'b1, 12'h123, 2, 0, 1'b0, 12'h000};
        tbl[3] = '{1'b1, 12'h456, 3, 0, 1'b0, 12'h456};
        tbl[4] = '{1'b1, 12'h789, 4, 0, 1'b0, 12'h789};
        tbl[5] = '{1'b0, 12'hFFF, 4, 0, 1'b0, 12'h789};

        repeat (3) @(posedge CLK);
        #1;
        model_reset();
        check("reset_state", dut_vec(), exp_vec());
        $display("reset: hpos=%0d vpos=%0d hblk=%b vblk=%b hsyn=%b vsyn=%b",
                 HPOS, VPOS, HBLK, VBLK, HSYN, VSYN);
        RESET_N = 1'b1;

        for (int i = 0; i < 6; i++) begin
            step(tbl[i].ce, tbl[i].rgb, 4'd0, 4'd0);
            check("tbl_hpos", 32'(HPOS), 32'(tbl[i].hpos));
            check("tbl_vpos", 32'(VPOS), 32'(tbl[i].vpos));
            check("tbl_hblk", 32'(HBLK), 32'(tbl[i].hblk));
            check("tbl_orgb", 32'(oRGB), 32'(tbl[i].orgb));
            $display("vec %0d: ce=%b rgb=%h -> hpos=%0d vpos=%0d orgb=%h",
                     i, tbl[i].ce, tbl[i].rgb, HPOS, VPOS, oRGB);
        end

        // Mid-frame offset change only takes effect at the next frame.
        sync_frame(4'd0, 4'd0);
        scan_line(4'd5, mn, mx);
        check("hs_keep_lo", 32'(mn), 32'd22);
        check("hs_keep_hi", 32'(mx), 32'd25);
        sync_frame(4'd5, 4'd0);
        scan_line(4'd0, mn, mx);
        check("hs_plus5_lo", 32'(mn), 32'd27);
        check("hs_plus5_hi", 32'(mx), 32'd30);
        sync_frame(4'h8, 4'd0);
        scan_line(4'd0, mn, mx);
        check("hs_minus8_lo", 32'(mn), 32'd14);
        check("hs_minus8_hi", 32'(mx), 32'd17);

        // Reset mid-frame with vo=3 latched.
        sync_frame(4'd0, 4'd3);
        for (int i = 0; i < 50; i++) step(1'b1, DW'($urandom), 4'd0, 4'd3);
        RESET_N = 1'b0;
        #1;
        model_reset();
        check("reset_async", dut_vec(), exp_vec());
        CE = 1'b1;
        @(posedge CLK);
        #1;
        check("reset_hold", dut_vec(), exp_vec());
        $display("mid-frame reset: hpos=%0d vpos=%0d lstart=%b fstart=%b", HPOS, VPOS, LSTART, FSTART);
        RESET_N = 1'b1;
        mn = 999; mx = -1;
        for (int i = 0; i < HT * VT - 1; i++) begin
            step(1'b1, DW'($urandom), 4'd0, 4'd3);
            if (VSYN == VS_ACT) begin
                if (int'(VPOS) < mn) mn = int'(VPOS);
                if (int'(VPOS) > mx) mx = int'(VPOS);
            end
        end
        check("vs_after_reset_lo", 32'(mn), 32'd11);
        check("vs_after_reset_hi", 32'(mx), 32'd12);
        $display("frame after reset: vsync active %0d..%0d", mn, mx);

        // CE every 4th clock: frame period in clocks and strobe widths.
        sync_frame(4'd0, 4'd0);
        period = 0; ls_cnt = 0;
        for (int k = 1; k <= 4 * HT * VT + 8; k++) begin
            step((k % 4) == 0, DW'($urandom), 4'd0, 4'd0);
            if (LSTART) ls_cnt++;
            if (FSTART) begin
                period = k;
                break;
            end
        end
        check("fstart_period_clk", 32'(period), 32'(4 * HT * VT));
        check("lstart_count", 32'(ls_cnt), 32'(VT));
        step(1'b0, DW'($urandom), 4'd0, 4'd0);
        check("fstart_width", 32'(FSTART), 32'd0);
        check("lstart_width", 32'(LSTART), 32'd0);
        $display("ce/4: frame period %0d clk, %0d line strobes", period, ls_cnt);

        // Randomised CE, offsets and pixel data against the model.
        for (int i = 0; i < 8000; i++) begin
            step($urandom_range(0, 3) != 0, DW'($urandom), 4'($urandom), 4'($urandom));
            if (m_fs) $display("random frame start: ho=%0d vo=%0d", m_ho, m_vo);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
